inst_cache: RTL
===============

// Module: inst_cache
// PURPOSE
// - Direct-mapped, one-word-per-line instruction cache between the fetch stage and the memory controller.
// - Hit: returns the instruction one cycle after the request.
// - Miss: issues a 32-bit instruction read to the memory controller, holds it until the controller's
//   done pulse, fills the line, then returns the word.
// - Only producer of the controller's instruction-read request/address; only consumer of its
//   instruction done flag and result.
// PARAMETERS
// - INDEX_W  6  index bits; 2**INDEX_W lines; tag = addr[31:2+INDEX_W]; addr[1:0] ignored
// PORTS
// - clk      in   1   clock
// - reset    in   1   synchronous, active-low reset
// - rdy      in   1   global ready; when low, all state and outputs hold
// - flush    in   1   pipeline clear (mispredict); abandons any pending miss
// - if_req   in   1   fetch request; held with if_pc stable until if_vld
// - if_pc    in   32  fetch address
// - if_vld   out  1   one-cycle pulse: if_inst valid for the current if_pc
// - if_inst  out  32  instruction word
// - mc_req   out  1   instruction read request to the memory controller (level)
// - mc_addr  out  32  read address, {pc[31:2],2'b00}
// - mc_done  in   1   controller done pulse (one cycle)
// - mc_data  in   32  controller result, valid when mc_done=1
// BEHAVIOUR
// - Reset (reset=0 at posedge):
//   - all valid bits cleared; state=IDLE
//   - if_vld=0, if_inst=0, mc_req=0, mc_addr=0
//   - tag/data arrays are not cleared
// - Priority at each posedge: reset > ~rdy (hold) > flush > normal operation.
// - State IDLE:
//   - if_req=1 and valid[idx] and tag[idx]==if_pc tag (hit):
//     - next cycle: if_vld=1, if_inst=data[idx]
//     - latency 1; back-to-back hits give one word per cycle
//   - if_req=1 and miss:
//     - latch miss_addr=if_pc
//     - next cycle: mc_req=1, mc_addr={if_pc[31:2],2'b00}
//     - state -> MISS; if_vld=0
//   - if_req=0: if_vld=0
// - State MISS:
//   - mc_req and mc_addr are held constant until mc_done is sampled high.
//   - On mc_done=1:
//     - data[idx]=mc_data, tag[idx]=miss tag, valid[idx]=1
//     - mc_req=0 next cycle; state -> IDLE
//     - if if_req=1 and if_pc==miss_addr: next cycle if_vld=1, if_inst=mc_data
//     - else: line is filled only; if_vld=0
//   - The controller may start a spurious read in the cycle mc_done arrives; it is abandoned
//     when mc_req drops. Any mc_done arriving while in IDLE is ignored.
// - flush=1 (rdy=1):
//   - state -> IDLE, mc_req=0, if_vld=0 next cycle
//   - a pending miss is abandoned with no fill, even if mc_done=1 in the same cycle
//   - valid bits are kept
// - if_vld is always a single-cycle pulse per completed request.
// - The requester drops or changes if_req/if_pc in the cycle after if_vld; otherwise the next
//   cycle counts as a new request.
// - Index = if_pc[2+INDEX_W-1:2]; a conflicting address overwrites the line (no replacement choice).
// - rdy=0 mid-miss: mc_req, mc_addr and state are frozen; an mc_done pulse seen while rdy=0 is not
//   lost (controller is also stalled by rdy).
// CONFIGURATION
// - ICACHE_STATS_EN defined:
//   - extra outputs stat_hit[31:0] and stat_miss[31:0], reset to 0
//   - stat_hit +1 per hit return; stat_miss +1 per miss entry (IDLE->MISS)
//   - both wrap at 2**32; unaffected by flush; frozen when rdy=0
// - ICACHE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - Reset, then if_req=1, if_pc=0x0000_0000 -> mc_req=1, mc_addr=0x0 next cycle;
//   mc_done=1, mc_data=0x0000_0013 -> if_vld=1, if_inst=0x13 next cycle; mc_req=0.
// - Re-request pc=0x0 -> if_vld=1, if_inst=0x13 one cycle later; mc_req stays 0.
// - pc=0x100 with INDEX_W=6 (same index as 0x0): miss, fill 0xDEADBEEF ->
//   next pc=0x0 misses again and mc_addr=0x0.
// - Miss on 0x40, flush=1 in same cycle as mc_done=1 with 0x12345678 ->
//   if_vld stays 0, mc_req=0, later pc=0x40 misses again.
// - rdy=0 for 3 cycles during MISS -> mc_req=1, mc_addr unchanged; after rdy=1 and
//   mc_done -> normal fill and return.
// - ICACHE_STATS_EN: sequence miss 0x0, hit 0x0, hit 0x0, miss 0x4 -> stat_hit=2, stat_miss=2.

Source files
------------

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory controller.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module inst_cache #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_vld,
    output logic [31:0] if_inst,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hit,
    output logic [31:0] stat_miss
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               ifVld_q, ifVld_d;
    logic [31:0]        ifInst_q, ifInst_d;
    logic               mcReq_q, mcReq_d;
    logic [31:0]        mcAddr_q, mcAddr_d;
    logic [31:0]        missAddr_q, missAddr_d;
    logic [LINES-1:0]   valid_q;

    logic [TAG_W-1:0]   tagMem_q  [LINES];
    logic [31:0]        dataMem_q [LINES];

    logic [INDEX_W-1:0] lookupIdx;
    logic [TAG_W-1:0]   lookupTag;
    logic [INDEX_W-1:0] fillIdx;
    logic [TAG_W-1:0]   fillTag;
    logic               lookupHit;
    logic               fillEn;

    assign lookupIdx = if_pc[INDEX_W+1:2];
    assign lookupTag = if_pc[31:INDEX_W+2];
    assign fillIdx   = missAddr_q[INDEX_W+1:2];
    assign fillTag   = missAddr_q[31:INDEX_W+2];
    assign lookupHit = valid_q[lookupIdx] && (tagMem_q[lookupIdx] == lookupTag);

    always_comb begin
        state_d    = state_q;
        ifVld_d    = 1'b0;
        ifInst_d   = ifInst_q;
        mcReq_d    = mcReq_q;
        mcAddr_d   = mcAddr_q;
        missAddr_d = missAddr_q;
        fillEn     = 1'b0;
        if (!rdy) begin
            ifVld_d = ifVld_q;
        end else if (flush) begin
            state_d = IDLE;
            mcReq_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_req) begin
                        if (lookupHit) begin
                            ifVld_d  = 1'b1;
                            ifInst_d = dataMem_q[lookupIdx];
                        end else begin
                            missAddr_d = if_pc;
                            mcReq_d    = 1'b1;
                            mcAddr_d   = {if_pc[31:2], 2'b00};
                            state_d    = MISS;
                        end
                    end
                end
                MISS: begin
                    // The word is returned only if the fetch is still waiting for this same address.
                    if (mc_done) begin
                        fillEn  = 1'b1;
                        mcReq_d = 1'b0;
                        state_d = IDLE;
                        if (if_req && (if_pc == missAddr_q)) begin
                            ifVld_d  = 1'b1;
                            ifInst_d = mc_data;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ifVld_q    <= 1'b0;
            ifInst_q   <= '0;
            mcReq_q    <= 1'b0;
            mcAddr_q   <= '0;
            missAddr_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            ifVld_q    <= ifVld_d;
            ifInst_q   <= ifInst_d;
            mcReq_q    <= mcReq_d;
            mcAddr_q   <= mcAddr_d;
            missAddr_q <= missAddr_d;
            if (fillEn) begin
                valid_q[fillIdx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (reset && fillEn) begin
            tagMem_q[fillIdx]  <= fillTag;
            dataMem_q[fillIdx] <= mc_data;
        end
    end

    assign if_vld  = ifVld_q;
    assign if_inst = ifInst_q;
    assign mc_req  = mcReq_q;
    assign mc_addr = mcAddr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] statHit_q;
    logic [31:0] statMiss_q;
    logic        hitEvt;
    logic        missEvt;

    assign hitEvt  = rdy && !flush && (state_q == IDLE) && if_req && lookupHit;
    assign missEvt = rdy && !flush && (state_q == IDLE) && if_req && !lookupHit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            statHit_q  <= '0;
            statMiss_q <= '0;
        end else begin
            if (hitEvt) begin
                statHit_q <= statHit_q + 32'd1;
            end
            if (missEvt) begin
                statMiss_q <= statMiss_q + 32'd1;
            end
        end
    end

    assign stat_hit  = statHit_q;
    assign stat_miss = statMiss_q;
`else
    // No counters in this build.
`endif

endmodule
